fpga_wdi_gen: RTL and testbench

//  Multi-channel watchdog kick generator for external supervisor ICs.
//  Per channel: programmable period and high width, counted in PULSE_100US ticks, on the OPB_CLK domain.

---
 rtl/fpga_wdi_gen.sv | 123 ++++++++++++
 tb/tb_fpga_wdi_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_wdi_gen.sv
// Multi-channel watchdog kick generator with programmable period/high width in PULSE_100US ticks.
// Define FPGA_WDI_HB_EN to build the firmware heartbeat supervisor that gates all kicks.
module fpga_wdi_gen #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned HB_TIMEOUT = 50
) (
    input  logic                    opb_clk_i,
    input  logic                    opb_rst_i,
    input  logic                    pulse_100us_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    input  logic [NUM_CH*CNT_W-1:0] high_i,
    input  logic                    sw_hb_i,
    input  logic                    hb_clr_i,
    output logic [NUM_CH-1:0]       wd_trig_o,
    output logic                    hb_fault_o
);

    logic hold_all;

`ifdef FPGA_WDI_HB_EN
    localparam logic [15:0] HbTimeout = 16'(HB_TIMEOUT);

    logic [15:0] hb_cnt_q, hb_cnt_d;
    logic        hb_fault_q, hb_fault_d;

    // Clear beats heartbeat, heartbeat beats tick; counter saturates at the timeout.
    always_comb begin
        hb_cnt_d   = hb_cnt_q;
        hb_fault_d = hb_fault_q;
        if (hb_clr_i) begin
            hb_cnt_d   = '0;
            hb_fault_d = 1'b0;
        end else if (sw_hb_i) begin
            hb_cnt_d = '0;
        end else if (pulse_100us_i && (hb_cnt_q != HbTimeout)) begin
            hb_cnt_d = hb_cnt_q + 16'd1;
            if (hb_cnt_d == HbTimeout) begin
                hb_fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge opb_clk_i or posedge opb_rst_i) begin
        if (opb_rst_i) begin
            hb_cnt_q   <= '0;
            hb_fault_q <= 1'b0;
        end else begin
            hb_cnt_q   <= hb_cnt_d;
            hb_fault_q <= hb_fault_d;
        end
    end

    assign hold_all   = hb_fault_q;
    assign hb_fault_o = hb_fault_q;
`else
    logic unused_hb;

    assign unused_hb  = sw_hb_i ^ hb_clr_i;
    assign hold_all   = 1'b0;
    assign hb_fault_o = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] per_in, high_in, per_e, high_e;
        logic [CNT_W-1:0] ph_q, ph_d, per_q, per_d, high_q, high_d;
        logic             trig_q, trig_d;

        assign per_in  = period_i[g*CNT_W +: CNT_W];
        assign high_in = high_i[g*CNT_W +: CNT_W];

        // Clamp so every period has at least one high and one low tick.
        always_comb begin
            per_e = (per_in < CNT_W'(2)) ? CNT_W'(2) : per_in;
            if (high_in == '0) begin
                high_e = CNT_W'(1);
            end else if (high_in >= per_e) begin
                high_e = per_e - CNT_W'(1);
            end else begin
                high_e = high_in;
            end
        end

        always_comb begin
            ph_d   = ph_q;
            per_d  = per_q;
            high_d = high_q;
            trig_d = trig_q;
            if (!ch_en_i[g] || hold_all) begin
                ph_d   = '0;
                trig_d = 1'b0;
            end else if (pulse_100us_i) begin
                if (ph_q == '0) begin
                    per_d  = per_e;
                    high_d = high_e;
                    trig_d = 1'b1;
                    ph_d   = CNT_W'(1);
                end else begin
                    trig_d = (ph_q < high_q);
                    ph_d   = (ph_q == per_q - CNT_W'(1)) ? '0 : ph_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge opb_clk_i or posedge opb_rst_i) begin
            if (opb_rst_i) begin
                ph_q   <= '0;
                per_q  <= '0;
                high_q <= '0;
                trig_q <= 1'b0;
            end else begin
                ph_q   <= ph_d;
                per_q  <= per_d;
                high_q <= high_d;
                trig_q <= trig_d;
            end
        end

        assign wd_trig_o[g] = trig_q;
    end

endmodule

// File: tb/tb_fpga_wdi_gen.sv
// Bench for fpga_wdi_gen: per-channel schedule-queue model checked every cycle, plus directed
// literal checks of the default kick, clamping, mid-period reprogramming, disable and reset.
module tb_fpga_wdi_gen;
    localparam int NUM_CH     = 2;
    localparam int CNT_W      = 8;
    localparam int HB_TIMEOUT = 50;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    pulse = 1'b0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic [NUM_CH*CNT_W-1:0] period = '0;
    logic [NUM_CH*CNT_W-1:0] high = '0;
    logic                    sw_hb = 1'b0;
    logic                    hb_clr = 1'b0;
    logic [NUM_CH-1:0]       wd_trig;
    logic                    hb_fault;

    int vectors = 0;
    int miscompares = 0;

    fpga_wdi_gen #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .HB_TIMEOUT(HB_TIMEOUT)
    ) dut (
        .opb_clk_i    (clk),
        .opb_rst_i    (rst),
        .pulse_100us_i(pulse),
        .ch_en_i      (ch_en),
        .period_i     (period),
        .high_i       (high),
        .sw_hb_i      (sw_hb),
        .hb_clr_i     (hb_clr),
        .wd_trig_o    (wd_trig),
        .hb_fault_o   (hb_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: at period start the whole period is queued as a list of output levels.
    bit sched[NUM_CH][$];
    bit exp_trig[NUM_CH];
    int hb_cnt = 0;
    bit exp_fault = 0;

    always @(posedge clk or posedge rst) begin
        bit blocked;
        int pe, he;
        blocked = 0;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sched[c].delete();
                exp_trig[c] = 0;
            end
            hb_cnt    = 0;
            exp_fault = 0;
        end else begin
`ifdef FPGA_WDI_HB_EN
            blocked = exp_fault;
            if (hb_clr) begin
                hb_cnt    = 0;
                exp_fault = 0;
            end else if (sw_hb) begin
                hb_cnt = 0;
            end else if (pulse && hb_cnt < HB_TIMEOUT) begin
                hb_cnt++;
                if (hb_cnt == HB_TIMEOUT) exp_fault = 1;
            end
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                if (!ch_en[c] || blocked) begin
                    sched[c].delete();
                    exp_trig[c] = 0;
                end else if (pulse) begin
                    if (sched[c].size() == 0) begin
                        pe = int'(period[c*CNT_W +: CNT_W]);
                        if (pe < 2) pe = 2;
                        he = int'(high[c*CNT_W +: CNT_W]);
                        if (he < 1) he = 1;
                        if (he > pe - 1) he = pe - 1;
                        for (int k = 0; k < pe; k++) sched[c].push_back(k < he);
                    end
                    exp_trig[c] = sched[c].pop_front();
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("model wd_trig[%0d]", c), 32'(wd_trig[c]), 32'(exp_trig[c]));
        end
        check("model hb_fault", 32'(hb_fault), 32'(exp_fault));
    end

    task automatic step(input bit p);
        pulse = p;
        @(posedge clk);
        @(negedge clk);
        pulse = 1'b0;
    endtask

    task automatic tick();
        step(1'b0);
        step(1'b1);
    endtask

    task automatic set_ch(input int c, input int p, input int h);
        period[c*CNT_W +: CNT_W] = CNT_W'(p);
        high[c*CNT_W +: CNT_W]   = CNT_W'(h);
    endtask

    task automatic restart_ch0();
        ch_en[0] = 1'b0;
        step(1'b0);
        ch_en[0] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        sw_hb = 1'b1;
        repeat (3) @(negedge clk);
        check("reset wd_trig", 32'(wd_trig), 32'd0);
        check("reset hb_fault", 32'(hb_fault), 32'd0);
        rst = 1'b0;
        step(1'b0);

        // Defaults: high on ticks 1, 11, 21, registered one clock after the strobe.
        set_ch(0, 10, 1);
        set_ch(1, 10, 1);
        ch_en = 2'b11;
        step(1'b0);
        pulse = 1'b1;
        check("T1 no combinational path", 32'(wd_trig[0]), 32'd0);
        for (int t = 1; t <= 30; t++) begin
            if (t == 1) step(1'b1);
            else tick();
            check($sformatf("T1 tick %0d", t), 32'(wd_trig[0]), 32'((t % 10) == 1));
        end

        // Disable while high drops the kick on the next clock; re-enable kicks on next tick.
        tick();
        check("T4 high before drop", 32'(wd_trig[0]), 32'd1);
        ch_en[0] = 1'b0;
        step(1'b0);
        check("T4 ch0 dropped", 32'(wd_trig[0]), 32'd0);
        check("T4 ch1 unaffected", 32'(wd_trig[1]), 32'd1);
        ch_en[0] = 1'b1;
        step(1'b0);
        check("T4 no kick without tick", 32'(wd_trig[0]), 32'd0);
        step(1'b1);
        check("T4 kick on first tick", 32'(wd_trig[0]), 32'd1);

        // PERIOD=1, HIGH=0 clamp to a 2-tick period with 1 tick high.
        set_ch(0, 1, 0);
        restart_ch0();
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("T2 tick %0d", t), 32'(wd_trig[0]), 32'(t % 2));
        end

        // Period change mid-period applies only at the next period start.
        set_ch(0, 10, 1);
        restart_ch0();
        for (int t = 1; t <= 20; t++) begin
            if (t == 6) set_ch(0, 4, 1);
            tick();
            check($sformatf("T3 tick %0d", t), 32'(wd_trig[0]),
                  32'((t <= 10) ? (t == 1) : ((t - 11) % 4 == 0)));
        end

        // Asynchronous reset in the middle of a high phase.
        set_ch(0, 10, 3);
        restart_ch0();
        tick();
        check("T5 high before reset", 32'(wd_trig[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("T5 async wd_trig", 32'(wd_trig), 32'd0);
        check("T5 async hb_fault", 32'(hb_fault), 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (3) step(1'b0);
        check("T5 idle after release", 32'(wd_trig), 32'd0);

`ifdef FPGA_WDI_HB_EN
        // Heartbeat timeout kills all kicks; clear restores on the next tick.
        set_ch(0, 10, 1);
        sw_hb  = 1'b0;
        hb_clr = 1'b1;
        step(1'b0);
        hb_clr = 1'b0;
        for (int t = 1; t <= 49; t++) tick();
        check("T6 no fault at 49", 32'(hb_fault), 32'd0);
        tick();
        check("T6 fault at 50", 32'(hb_fault), 32'd1);
        step(1'b0);
        check("T6 kicks blocked", 32'(wd_trig), 32'd0);
        repeat (5) tick();
        check("T6 still blocked", 32'(wd_trig), 32'd0);
        hb_clr = 1'b1;
        step(1'b0);
        hb_clr = 1'b0;
        check("T6 fault cleared", 32'(hb_fault), 32'd0);
        step(1'b1);
        check("T6 kick resumes", 32'(wd_trig), 32'(2'b11));
        for (int t = 1; t <= 200; t++) begin
            step(1'b0);
            sw_hb = (t % 49 == 0);
            step(1'b1);
            sw_hb = 1'b0;
        end
        check("T6 heartbeat holds off fault", 32'(hb_fault), 32'd0);
`endif

        // Randomized traffic against the model.
        sw_hb = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 79) == 0) ch_en[c] = ~ch_en[c];
                if ($urandom_range(0, 49) == 0)
                    set_ch(c, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
            end
            sw_hb  = ($urandom_range(0, 149) == 0);
            hb_clr = ($urandom_range(0, 399) == 0);
            step($urandom_range(0, 2) == 0);
            sw_hb  = 1'b0;
            hb_clr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
